// File: rtl/alsu_pkg.sv
// Package for the pipelined ALSU.
// Holds the opcode encodings, the control FSM state type and the helper
// function that decides whether a command bundle is illegal.
// Ports: none (package).
package alsu_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_XOR    = 3'd1;
  localparam logic [2:0] OP_ADD    = 3'd2;
  localparam logic [2:0] OP_MULT   = 3'd3;
  localparam logic [2:0] OP_SHIFT  = 3'd4;
  localparam logic [2:0] OP_ROTATE = 3'd5;
  localparam logic [2:0] OP_INV6   = 3'd6;
  localparam logic [2:0] OP_INV7   = 3'd7;

  localparam logic [15:0] LEDS_ON  = 16'hFFFF;
  localparam logic [15:0] LEDS_OFF = 16'h0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alsu_state_t;

  // Opcodes 6/7 are never legal; reductions only make sense for AND/XOR.
  function automatic logic opcode_invalid(input logic [2:0] op,
                                          input logic       red_a,
                                          input logic       red_b);
    return (op == OP_INV6) || (op == OP_INV7) ||
           ((red_a | red_b) && (op >= OP_ADD));
  endfunction

endpackage

// File: rtl/alsu_seq_mult.sv
// Iterative shift-add multiplier for the ALSU.
// start loads the operands; one multiplier bit is consumed per clock and
// done is raised combinationally during the WIDTH-th busy cycle, with the
// complete product presented on product in that same cycle so the caller
// can register it on the closing edge.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (aborts a multiply)
//   start        load a/b and begin (ignored while a multiply runs)
//   a, b         WIDTH-bit unsigned operands
//   done         high in the last busy cycle
//   product      2*WIDTH-bit result, valid while done is high
module alsu_seq_mult
  #(parameter int WIDTH = 3)
  (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
  );

  localparam int OW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  logic [OW-1:0]    mcand;
  logic [OW-1:0]    acc;
  logic [OW-1:0]    acc_next;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             active;

  // The final partial product is folded in combinationally so the result is
  // ready on the last busy cycle instead of one clock later.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = active && (cnt == CNT_W'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start && !active) begin
      mcand  <= OW'(a);
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alsu_pipe.sv
// WIDTH-bit arithmetic/logic/shift unit with a valid/ready command input,
// registered 2*WIDTH-bit result, iterative multiply and an invalid-op alarm
// shown on the LEDs.
// Build option: define ALSU_LED_BLINK_EN to make the alarm blink every
// BLINK_DIV clocks; without it the LEDs stay solidly lit during an alarm and
// no blink divider exists.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   command handshake (ready only when idle)
//   A, B                  WIDTH-bit operands
//   opcode                0 AND,1 XOR,2 ADD,3 MULT,4 SHIFT,5 ROTATE,6/7 invalid
//   cin                   ADD carry-in (used when FULL_ADDER == "ON")
//   serial_in             fill bit for SHIFT
//   direction             1 left, 0 right for SHIFT/ROTATE
//   red_op_A / red_op_B   reduce A / B (AND/XOR only)
//   bypass_A / bypass_B   pass A / B straight through
//   out_valid             one-cycle pulse when out/err update
//   out                   registered 2*WIDTH-bit result
//   err                   last completed command was invalid
//   leds                  alarm display
//   busy                  multiply in progress
module alsu_pipe
  import alsu_pkg::*;
  #(parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    BLINK_DIV      = 4)
  (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         opcode,
    input  logic               cin,
    input  logic               serial_in,
    input  logic               direction,
    input  logic               red_op_A,
    input  logic               red_op_B,
    input  logic               bypass_A,
    input  logic               bypass_B,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] out,
    output logic               err,
    output logic [15:0]        leds,
    output logic               busy
  );

  localparam int OW     = 2 * WIDTH;
  localparam bit PRIO_B = (INPUT_PRIORITY == "B");
  localparam bit FA_ON  = (FULL_ADDER == "ON");

  alsu_state_t state, next_state;

  logic             accept;
  logic             bypass_any;
  logic             use_b_bypass;
  logic             red_any;
  logic             use_b_red;
  logic [WIDTH-1:0] red_src;
  logic             cmd_invalid;
  logic             is_mult_cmd;
  logic [OW-1:0]    single_res;
  logic [WIDTH:0]   add_sum;
  logic             mult_start;
  logic             mult_done;
  logic [OW-1:0]    mult_product;

  assign in_ready   = (state == ST_IDLE);
  assign busy       = (state == ST_BUSY);
  assign accept     = in_valid & in_ready;
  assign mult_start = accept & is_mult_cmd;

  assign add_sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin & FA_ON};

  // Command decode: bypass wins over the invalid check, which wins over the
  // opcode. MULT produces no immediate result; it only flags the start.
  always_comb begin
    single_res   = '0;
    is_mult_cmd  = 1'b0;
    bypass_any   = bypass_A | bypass_B;
    use_b_bypass = bypass_B & (~bypass_A | PRIO_B);
    red_any      = red_op_A | red_op_B;
    use_b_red    = red_op_B & (~red_op_A | PRIO_B);
    red_src      = use_b_red ? B : A;
    cmd_invalid  = opcode_invalid(opcode, red_op_A, red_op_B);
    if (bypass_any) begin
      single_res = use_b_bypass ? OW'(B) : OW'(A);
    end else if (!cmd_invalid) begin
      case (opcode)
        OP_AND:    single_res = red_any ? OW'(&red_src) : OW'(A & B);
        OP_XOR:    single_res = red_any ? OW'(^red_src) : OW'(A ^ B);
        OP_ADD:    single_res = OW'(add_sum);
        OP_MULT:   is_mult_cmd = 1'b1;
        OP_SHIFT:  single_res = direction ? {out[OW-2:0], serial_in}
                                          : {serial_in, out[OW-1:1]};
        OP_ROTATE: single_res = direction ? {out[OW-2:0], out[OW-1]}
                                          : {out[0], out[OW-1:1]};
        default:   single_res = '0;
      endcase
    end
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Only a multiply leaves IDLE; the multiplier's done ends the BUSY phase.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (mult_start) next_state = ST_BUSY;
      ST_BUSY: if (mult_done)  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  alsu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mult_start),
    .a       (A),
    .b       (B),
    .done    (mult_done),
    .product (mult_product)
  );

  // Result register: single-cycle commands land on the accepting edge, a
  // multiply lands on its final busy edge. out holds between updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mult_cmd) begin
        out       <= single_res;
        out_valid <= 1'b1;
        err       <= cmd_invalid & ~bypass_any;
      end else if (busy && mult_done) begin
        out       <= mult_product;
        out_valid <= 1'b1;
        err       <= 1'b0;
      end
    end
  end

  logic accept_bad;
  logic accept_good;

  assign accept_bad  = accept & cmd_invalid & ~bypass_any;
  assign accept_good = accept & ~accept_bad;

`ifdef ALSU_LED_BLINK_EN
  localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic             alarm;
  logic [DIV_W-1:0] blink_div;

  // Alarm with blinking: an invalid command (re)starts the phase lit, a good
  // command clears it; in between the LEDs invert every BLINK_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm     <= 1'b0;
      leds      <= LEDS_OFF;
      blink_div <= '0;
    end else if (accept_bad) begin
      alarm     <= 1'b1;
      leds      <= LEDS_ON;
      blink_div <= '0;
    end else if (accept_good) begin
      alarm     <= 1'b0;
      leds      <= LEDS_OFF;
      blink_div <= '0;
    end else if (alarm) begin
      if (blink_div == DIV_W'(BLINK_DIV - 1)) begin
        blink_div <= '0;
        leds      <= ~leds;
      end else begin
        blink_div <= blink_div + DIV_W'(1);
      end
    end
  end
`else
  // Static alarm: lit solid from an invalid command until a good one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= LEDS_OFF;
    end else if (accept_bad) begin
      leds <= LEDS_ON;
    end else if (accept_good) begin
      leds <= LEDS_OFF;
    end
  end
`endif

endmodule

// File: tb/tb_alsu_pipe.sv
// Self-checking bench for alsu_pipe. Two instances share the stimulus:
// dut0 uses INPUT_PRIORITY "A" / FULL_ADDER "ON", dut1 uses "B" / "OFF".
// A cycle-level behavioural model predicts every output after each edge.
module tb_alsu_pipe;

  localparam int W     = 3;
  localparam int OW    = 2 * W;
  localparam int MASK  = (1 << OW) - 1;
  localparam int BLINK = 4;
`ifdef ALSU_LED_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, cin, serial_in, direction;
  logic          red_op_A, red_op_B, bypass_A, bypass_B;
  logic [W-1:0]  A, B;
  logic [2:0]    opcode;

  logic          rdy0, ov0, err0, busy0, rdy1, ov1, err1, busy1;
  logic [OW-1:0] out0, out1;
  logic [15:0]   leds0, leds1;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int m_out[2];
  int m_err, m_valid, mult_left, m_prod, m_age;
  bit m_alarm;

  always #5 clk = ~clk;

  alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .BLINK_DIV(BLINK)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .A(A), .B(B),
    .opcode(opcode), .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out_valid(ov0), .out(out0), .err(err0), .leds(leds0), .busy(busy0));

  alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .BLINK_DIV(BLINK)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .A(A), .B(B),
    .opcode(opcode), .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out_valid(ov1), .out(out1), .err(err1), .leds(leds1), .busy(busy1));

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_leds();
    if (!m_alarm) return 0;
    if (!BLINK_EN) return 'hFFFF;
    return ((m_age / BLINK) % 2) ? 0 : 'hFFFF;
  endfunction

  function automatic bit model_invalid();
    return (opcode >= 6) || ((red_op_A || red_op_B) && opcode >= 2);
  endfunction

  // Result of a single-cycle command for variant v (1 = priority B, no carry).
  function automatic int model_single(int v);
    int a = int'(A);
    int b = int'(B);
    int o = m_out[v];
    int sin = int'(serial_in);
    int src;
    bit pb = (v == 1);
    if (bypass_A && bypass_B) return pb ? b : a;
    if (bypass_A) return a;
    if (bypass_B) return b;
    if (model_invalid()) return 0;
    src = (red_op_A && red_op_B) ? (pb ? b : a) : (red_op_A ? a : b);
    case (int'(opcode))
      0: return (red_op_A || red_op_B) ? int'(src == (1 << W) - 1) : (a & b);
      1: return (red_op_A || red_op_B) ? ($countones(src) % 2) : (a ^ b);
      2: return a + b + (pb ? 0 : int'(cin));
      4: return direction ? (((o << 1) | sin) & MASK) : ((sin << (OW - 1)) | (o >> 1));
      5: return direction ? (((o << 1) | (o >> (OW - 1))) & MASK) : (((o & 1) << (OW - 1)) | (o >> 1));
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_out[0] = 0; m_out[1] = 0;
    m_err = 0; m_valid = 0; mult_left = 0; m_prod = 0; m_age = 0; m_alarm = 0;
  endtask

  task automatic model_edge();
    bit byp, bad;
    m_valid = 0;
    if (m_alarm) m_age++;
    if (mult_left > 0) begin
      mult_left--;
      if (mult_left == 0) begin
        m_out[0] = m_prod; m_out[1] = m_prod; m_err = 0; m_valid = 1;
      end
    end else if (in_valid) begin
      byp = bypass_A || bypass_B;
      bad = !byp && model_invalid();
      if (!byp && !bad && opcode == 3) begin
        mult_left = W;
        m_prod = int'(A) * int'(B);
      end else begin
        m_out[0] = model_single(0);
        m_out[1] = model_single(1);
        m_err = int'(bad);
        m_valid = 1;
      end
      if (bad) begin m_alarm = 1; m_age = 0; end
      else m_alarm = 0;
    end
  endtask

  task automatic compare_all();
    check_output("out0", 32'(out0), 32'(m_out[0]));
    check_output("out1", 32'(out1), 32'(m_out[1]));
    check_output("out_valid0", 32'(ov0), 32'(m_valid));
    check_output("out_valid1", 32'(ov1), 32'(m_valid));
    check_output("err0", 32'(err0), 32'(m_err));
    check_output("err1", 32'(err1), 32'(m_err));
    check_output("leds0", 32'(leds0), 32'(model_leds()));
    check_output("leds1", 32'(leds1), 32'(model_leds()));
    check_output("in_ready0", 32'(rdy0), 32'(mult_left == 0));
    check_output("in_ready1", 32'(rdy1), 32'(mult_left == 0));
    check_output("busy0", 32'(busy0), 32'(mult_left > 0));
    check_output("busy1", 32'(busy1), 32'(mult_left > 0));
  endtask

  // One clock: predict, let the edge happen, sample 1 time unit later.
  task automatic apply_stimulus();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_cmd(input logic v, input logic [2:0] op, input int a, input int b);
    in_valid = v; opcode = op; A = W'(a); B = W'(b);
    cin = 1'b0; serial_in = 1'b0; direction = 1'b0;
    red_op_A = 1'b0; red_op_B = 1'b0; bypass_A = 1'b0; bypass_B = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_cmd(1'b0, 3'd0, 0, 0);
    model_reset();
    #8;
    compare_all();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with carry: 7+7+1 on dut0, carry ignored on dut1
    set_cmd(1'b1, 3'd2, 7, 7); cin = 1'b1;
    apply_stimulus();
    check_output("add_full", 32'(out0), 32'd15);
    check_output("add_half", 32'(out1), 32'd14);

    // MULT 7*5, with a competing command held on in_valid while busy
    set_cmd(1'b1, 3'd3, 7, 5);
    apply_stimulus();
    set_cmd(1'b1, 3'd2, 1, 1);
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("mult_out", 32'(out0), 32'd35);
    check_output("mult_valid", 32'(ov0), 32'd1);
    set_cmd(1'b0, 3'd0, 0, 0);
    apply_stimulus();

    // invalid opcode, watch the alarm, then clear with AND
    set_cmd(1'b1, 3'd6, 3, 3);
    apply_stimulus();
    check_output("inv_err", 32'(err0), 32'd1);
    set_cmd(1'b0, 3'd0, 0, 0);
    for (int i = 0; i < 10; i++) apply_stimulus();
    set_cmd(1'b1, 3'd0, 6, 3);
    apply_stimulus();
    check_output("and_clear_leds", 32'(leds0), 32'd0);

    // bypass both with red_op and bad opcode: bypass dominates
    set_cmd(1'b1, 3'd7, 5, 2);
    bypass_A = 1'b1; bypass_B = 1'b1; red_op_A = 1'b1;
    apply_stimulus();
    check_output("bypass_pa", 32'(out0), 32'd5);
    check_output("bypass_pb", 32'(out1), 32'd2);

    // build 6'b100001, rotate left, rotate back, shift right with fill 1
    set_cmd(1'b1, 3'd0, 3, 0); bypass_A = 1'b1;
    apply_stimulus();
    set_cmd(1'b1, 3'd5, 0, 0);
    apply_stimulus();
    check_output("build_100001", 32'(out0), 32'b100001);
    set_cmd(1'b1, 3'd5, 0, 0); direction = 1'b1;
    apply_stimulus();
    check_output("rotl", 32'(out0), 32'b000011);
    set_cmd(1'b1, 3'd5, 0, 0);
    apply_stimulus();
    set_cmd(1'b1, 3'd4, 0, 0); serial_in = 1'b1;
    apply_stimulus();
    check_output("shr_fill1", 32'(out0), 32'b110000);

    // reset two clocks into a multiply
    set_cmd(1'b1, 3'd3, 7, 5);
    apply_stimulus();
    set_cmd(1'b0, 3'd0, 0, 0);
    apply_stimulus();
    apply_stimulus();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk); #1;
    compare_all();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      opcode    = 3'($urandom_range(0, 7));
      A         = W'($urandom);
      B         = W'($urandom);
      cin       = 1'($urandom);
      serial_in = 1'($urandom);
      direction = 1'($urandom);
      red_op_A  = ($urandom_range(0, 5) == 0);
      red_op_B  = ($urandom_range(0, 5) == 0);
      bypass_A  = ($urandom_range(0, 7) == 0);
      bypass_B  = ($urandom_range(0, 7) == 0);
      apply_stimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
